// File: rtl/load_store_unit_if.sv
// Bundle of core-side request/response and word-memory signals for the load/store unit.
// Handshake: a request transfers on a posedge where req_valid && req_ready are both high;
// resp_valid is a one-cycle pulse with no back-pressure, and mem_read/mem_write are one-cycle strobes.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_error,
           mem_read, mem_write, mem_address, mem_wdata
  );

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_error,
           mem_read, mem_write, mem_address, mem_wdata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: maps RISC-V byte/half/word accesses onto a word-only memory,
// doing read-modify-write for sub-word stores and extending load data.
module load_store_unit #(
  parameter int unsigned DEPTH_WORDS = 256
) (
  input  logic                 clock,
  input  logic                 reset,
  load_store_unit_if.slave     bus,
  output logic [2:0]           dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_READ     = 3'd1,
    S_RMW_READ = 3'd2,
    S_WRITE    = 3'd3,
    S_RESP     = 3'd4
  } state_t;

  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);

  state_t      state_q;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;
  logic        req_ready_q;
  logic        resp_valid_q;
  logic        resp_error_q;
  logic [31:0] resp_rdata_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic [31:0] mem_address_q;
  logic [31:0] mem_wdata_q;

  logic        funct3_ok;
  logic        align_ok;
  logic        range_ok;
  logic        req_err;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data_d;
  logic [31:0] st_word_d;

  always_comb begin
    case (bus.req_funct3)
      3'b000, 3'b001, 3'b010: funct3_ok = 1'b1;
      3'b100, 3'b101:         funct3_ok = !bus.req_write;
      default:                funct3_ok = 1'b0;
    endcase
    align_ok = 1'b1;
    if (bus.req_funct3[1:0] == 2'b01) align_ok = !bus.req_addr[0];
    if (bus.req_funct3[1:0] == 2'b10) align_ok = (bus.req_addr[1:0] == 2'b00);
    range_ok = (bus.req_addr < ADDR_LIMIT);
    req_err  = !(funct3_ok && align_ok && range_ok);
  end

  // Lane extraction for loads and lane merge for sub-word stores, both from the returned word.
  always_comb begin
    case (lane_q)
      2'd0:    ld_byte = bus.mem_rdata[7:0];
      2'd1:    ld_byte = bus.mem_rdata[15:8];
      2'd2:    ld_byte = bus.mem_rdata[23:16];
      default: ld_byte = bus.mem_rdata[31:24];
    endcase
    ld_half = lane_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (funct3_q)
      3'b000:  ld_data_d = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_data_d = {24'h000000, ld_byte};
      3'b001:  ld_data_d = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_data_d = {16'h0000, ld_half};
      default: ld_data_d = bus.mem_rdata;
    endcase

    st_word_d = bus.mem_rdata;
    if (funct3_q[1:0] == 2'b00) begin
      case (lane_q)
        2'd0:    st_word_d[7:0]   = wdata_q[7:0];
        2'd1:    st_word_d[15:8]  = wdata_q[7:0];
        2'd2:    st_word_d[23:16] = wdata_q[7:0];
        default: st_word_d[31:24] = wdata_q[7:0];
      endcase
    end else if (lane_q[1]) begin
      st_word_d[31:16] = wdata_q;
    end else begin
      st_word_d[15:0] = wdata_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      funct3_q      <= 3'b000;
      lane_q        <= 2'b00;
      wdata_q       <= 16'h0000;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_error_q  <= 1'b0;
      resp_rdata_q  <= 32'h0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_address_q <= 32'h0;
      mem_wdata_q   <= 32'h0;
    end else begin
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            funct3_q    <= bus.req_funct3;
            lane_q      <= bus.req_addr[1:0];
            wdata_q     <= bus.req_wdata[15:0];
            req_ready_q <= 1'b0;
            if (req_err) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_error_q <= 1'b1;
              resp_rdata_q <= 32'h0;
            end else if (!bus.req_write) begin
              state_q       <= S_READ;
              mem_read_q    <= 1'b1;
              mem_address_q <= {bus.req_addr[31:2], 2'b00};
            end else if (bus.req_funct3[1:0] == 2'b10) begin
              state_q       <= S_WRITE;
              mem_write_q   <= 1'b1;
              mem_address_q <= {bus.req_addr[31:2], 2'b00};
              mem_wdata_q   <= bus.req_wdata;
            end else begin
              state_q       <= S_RMW_READ;
              mem_read_q    <= 1'b1;
              mem_address_q <= {bus.req_addr[31:2], 2'b00};
            end
          end
        end
        S_READ: begin
          state_q      <= S_RESP;
          resp_valid_q <= 1'b1;
          resp_error_q <= 1'b0;
          resp_rdata_q <= ld_data_d;
        end
        S_RMW_READ: begin
          state_q     <= S_WRITE;
          mem_write_q <= 1'b1;
          mem_wdata_q <= st_word_d;
        end
        S_WRITE: begin
          state_q      <= S_RESP;
          resp_valid_q <= 1'b1;
          resp_error_q <= 1'b0;
          resp_rdata_q <= 32'h0;
        end
        S_RESP: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // The write strobe is qualified by reset so an aborted WRITE cycle commits nothing.
  assign bus.mem_write   = mem_write_q & ~reset;
  assign bus.mem_read    = mem_read_q;
  assign bus.mem_address = mem_address_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.req_ready   = req_ready_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_rdata  = resp_rdata_q;
  assign bus.resp_error  = resp_error_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: word memory model on the bus, byte-array reference model,
// directed and randomized accesses, reset abort and held-valid sequences.
module tb_load_store_unit;

  localparam int DEPTH = 256;

  logic clock;
  logic reset;
  logic [2:0] dbg_state;

  load_store_unit_if bus ();

  load_store_unit #(.DEPTH_WORDS(DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // memory attached to the DUT, with a backdoor port for preloading
  logic [31:0] tb_mem [0:DEPTH-1];
  logic        bd_en = 1'b0;
  logic [7:0]  bd_idx = 8'h0;
  logic [31:0] bd_val = 32'h0;
  int rd_total = 0;
  int wr_total = 0;
  int both_total = 0;

  assign bus.mem_rdata = tb_mem[bus.mem_address[9:2]];

  always @(posedge clock) begin
    if (bus.mem_read)  rd_total <= rd_total + 1;
    if (bus.mem_write) wr_total <= wr_total + 1;
    if (bus.mem_read && bus.mem_write) both_total <= both_total + 1;
    if (bus.mem_write) tb_mem[bus.mem_address[9:2]] <= bus.mem_wdata;
    if (bd_en) tb_mem[bd_idx] <= bd_val;
  end

  // reference model: memory as a byte array, accesses interpreted from the ISA rules
  logic [7:0] ref_bytes [0:4*DEPTH-1];

  task automatic model_exec(input logic w, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wd, output logic err, output logic [31:0] rd,
                            output int lat, output int nr, output int nw);
    int size;
    bit legal;
    logic [31:0] v;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = w ? (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)
              : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    err = !legal || ((a % size) != 0) || (a >= 4 * DEPTH);
    rd = 32'h0; nr = 0; nw = 0;
    if (err) begin
      lat = 1;
    end else if (!w) begin
      v = 32'h0;
      for (int i = 0; i < size; i++) v = v | (32'(ref_bytes[a + i]) << (8 * i));
      if (f3 == 3'd0 && v[7])  v = v | 32'hFFFFFF00;
      if (f3 == 3'd1 && v[15]) v = v | 32'hFFFF0000;
      rd = v; lat = 2; nr = 1;
    end else begin
      for (int i = 0; i < size; i++) ref_bytes[a + i] = wd[8 * i +: 8];
      lat = (size == 4) ? 2 : 3;
      nr  = (size == 4) ? 0 : 1;
      nw  = 1;
    end
  endtask

  // driver tasks
  task automatic set_word(input int idx, input logic [31:0] val);
    bd_en  = 1'b1;
    bd_idx = idx[7:0];
    bd_val = val;
    @(negedge clock);
    bd_en = 1'b0;
    for (int i = 0; i < 4; i++) ref_bytes[idx * 4 + i] = val[8 * i +: 8];
  endtask

  // Called at a negedge; returns at the negedge where resp_valid is seen (or the budget ran out).
  task automatic do_req(input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input bit hold, output logic got,
                        output logic err, output logic [31:0] rd, output int lat,
                        output int nr, output int nw);
    int guard;
    int r0, w0;
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    guard = 0;
    while (!bus.req_ready && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    r0 = rd_total;
    w0 = wr_total;
    @(posedge clock);
    @(negedge clock);
    if (!hold) bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    got = bus.resp_valid;
    err = bus.resp_error;
    rd  = bus.resp_rdata;
    nr  = rd_total - r0;
    nw  = wr_total - w0;
  endtask

  // tests
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    n_checks++;
    if (bus.req_ready !== 1'b1 || bus.resp_valid !== 1'b0 || bus.resp_error !== 1'b0 ||
        bus.resp_rdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_resp: ready=%b valid=%b err=%b rdata=%h, required 1 0 0 00000000",
               bus.req_ready, bus.resp_valid, bus.resp_error, bus.resp_rdata);
    end
    n_checks++;
    if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0 || bus.mem_address !== 32'h0 ||
        bus.mem_wdata !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_mem: rd=%b wr=%b addr=%h wdata=%h, required 0 0 0 0",
               bus.mem_read, bus.mem_write, bus.mem_address, bus.mem_wdata);
    end
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) set_word(i, $urandom);
  endtask

  typedef struct {
    logic        w;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        err;
    int          lat;
    int          nr;
    int          nw;
  } dcase_t;

  task automatic test_directed();
    dcase_t tbl [16];
    logic got, err, e_err;
    logic [31:0] rd, e_rd;
    int lat, nr, nw, e_lat, e_nr, e_nw;
    tbl[0]  = '{1'b0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0, 2, 1, 0};
    tbl[1]  = '{1'b0, 3'b000, 32'h13,  32'h0,        32'hFFFFFF80, 1'b0, 2, 1, 0};
    tbl[2]  = '{1'b0, 3'b100, 32'h13,  32'h0,        32'h00000080, 1'b0, 2, 1, 0};
    tbl[3]  = '{1'b0, 3'b001, 32'h12,  32'h0,        32'hFFFF80FF, 1'b0, 2, 1, 0};
    tbl[4]  = '{1'b0, 3'b101, 32'h10,  32'h0,        32'h00000000, 1'b0, 2, 1, 0};
    tbl[5]  = '{1'b1, 3'b000, 32'h21,  32'h000000AB, 32'h0,        1'b0, 3, 1, 1};
    tbl[6]  = '{1'b1, 3'b001, 32'h22,  32'hFFFFCAFE, 32'h0,        1'b0, 3, 1, 1};
    tbl[7]  = '{1'b0, 3'b010, 32'h20,  32'h0,        32'hCAFEAB44, 1'b0, 2, 1, 0};
    tbl[8]  = '{1'b0, 3'b010, 32'h02,  32'h0,        32'h0,        1'b1, 1, 0, 0};
    tbl[9]  = '{1'b1, 3'b001, 32'h03,  32'h5555,     32'h0,        1'b1, 1, 0, 0};
    tbl[10] = '{1'b0, 3'b010, 32'h400, 32'h0,        32'h0,        1'b1, 1, 0, 0};
    tbl[11] = '{1'b0, 3'b011, 32'h00,  32'h0,        32'h0,        1'b1, 1, 0, 0};
    tbl[12] = '{1'b1, 3'b100, 32'h00,  32'h77,       32'h0,        1'b1, 1, 0, 0};
    tbl[13] = '{1'b1, 3'b010, 32'h3FC, 32'h12345678, 32'h0,        1'b0, 2, 0, 1};
    tbl[14] = '{1'b0, 3'b000, 32'h3FF, 32'h0,        32'h00000012, 1'b0, 2, 1, 0};
    tbl[15] = '{1'b0, 3'b000, 32'h3FE, 32'h0,        32'h00000034, 1'b0, 2, 1, 0};
    for (int i = 0; i < 16; i++) begin
      if (i == 0) set_word(4, 32'hDEADBEEF);
      if (i == 1) set_word(4, 32'h80FF0000);
      if (i == 5) set_word(8, 32'h11223344);
      model_exec(tbl[i].w, tbl[i].f3, tbl[i].a, tbl[i].wd, e_err, e_rd, e_lat, e_nr, e_nw);
      do_req(tbl[i].w, tbl[i].f3, tbl[i].a, tbl[i].wd, 1'b0, got, err, rd, lat, nr, nw);
      n_checks++;
      if (!got || err !== tbl[i].err || rd !== tbl[i].rd || lat != tbl[i].lat) begin
        n_fail++;
        $display("FAIL directed_%0d: got=%b err=%b rdata=%h lat=%0d, required err=%b rdata=%h lat=%0d",
                 i, got, err, rd, lat, tbl[i].err, tbl[i].rd, tbl[i].lat);
      end
      n_checks++;
      if (nr != tbl[i].nr || nw != tbl[i].nw) begin
        n_fail++;
        $display("FAIL directed_strobes_%0d: reads=%0d writes=%0d, required %0d %0d",
                 i, nr, nw, tbl[i].nr, tbl[i].nw);
      end
      @(negedge clock);
      n_checks++;
      if (bus.resp_valid !== 1'b0 || bus.resp_rdata !== rd || bus.resp_error !== err) begin
        n_fail++;
        $display("FAIL directed_hold_%0d: valid=%b rdata=%h err=%b, required 0 %h %b",
                 i, bus.resp_valid, bus.resp_rdata, bus.resp_error, rd, err);
      end
      if (i == 6) begin
        n_checks++;
        if (tb_mem[8] !== 32'hCAFEAB44) begin
          n_fail++;
          $display("FAIL directed_rmw_mem: mem[8]=%h, required cafeab44", tb_mem[8]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic w, got, err, e_err;
    logic [2:0] f3;
    logic [31:0] a, wd, rd, e_rd;
    int lat, nr, nw, e_lat, e_nr, e_nw, sel;
    for (int i = 0; i < 120; i++) begin
      w   = 1'($urandom_range(0, 1));
      sel = $urandom_range(0, 9);
      f3  = (sel == 0) ? 3'($urandom_range(0, 7)) : (w ? 3'($urandom_range(0, 2))
                       : ((sel < 5) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(4, 5))));
      sel = $urandom_range(0, 19);
      if (sel == 0)      a = $urandom;
      else if (sel == 1) a = 32'(4 * DEPTH) + 32'($urandom_range(0, 8));
      else if (sel < 6)  a = 32'($urandom_range(0, 4 * DEPTH - 1));
      else               a = 32'($urandom_range(0, 4 * DEPTH - 1)) & ~((f3[1:0] == 2'd2) ? 32'h3 :
                             (f3[1:0] == 2'd1) ? 32'h1 : 32'h0);
      wd = $urandom;
      model_exec(w, f3, a, wd, e_err, e_rd, e_lat, e_nr, e_nw);
      do_req(w, f3, a, wd, 1'b0, got, err, rd, lat, nr, nw);
      n_checks++;
      if (!got || err !== e_err || rd !== e_rd || lat != e_lat || nr != e_nr || nw != e_nw) begin
        n_fail++;
        $display("FAIL random_%0d w=%b f3=%0d a=%h: got=%b err=%b rd=%h lat=%0d r=%0d w=%0d, required err=%b rd=%h lat=%0d r=%0d w=%0d",
                 i, w, f3, a, got, err, rd, lat, nr, nw, e_err, e_rd, e_lat, e_nr, e_nw);
      end
    end
  endtask

  task automatic test_reset_mid_write();
    int guard, w0, seen;
    set_word(12, 32'hA5A55A5A);
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h30;
    bus.req_wdata  = 32'h12345678;
    guard = 0;
    while (!bus.req_ready && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    w0 = wr_total;
    @(posedge clock);
    @(negedge clock);
    bus.req_valid = 1'b0;
    n_checks++;
    if (bus.mem_write !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_in_write: mem_write=%b before reset, required 1", bus.mem_write);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if (bus.mem_write !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_strobe: mem_write=%b with reset high, required 0", bus.mem_write);
    end
    @(negedge clock);
    reset = 1'b0;
    n_checks++;
    if (wr_total != w0 || bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_state: writes=%0d ready=%b, required 0 1", wr_total - w0, bus.req_ready);
    end
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.resp_valid) seen++;
      @(negedge clock);
    end
    n_checks++;
    if (seen != 0 || tb_mem[12] !== 32'hA5A55A5A) begin
      n_fail++;
      $display("FAIL abort_resp: resp pulses=%0d mem[12]=%h, required 0 a5a55a5a", seen, tb_mem[12]);
    end
  endtask

  task automatic test_back_to_back();
    logic got, err, e_err;
    logic [31:0] rd, e_rd;
    int lat, nr, nw, e_lat, e_nr, e_nw, seen, r0;
    logic        bw  [3];
    logic [2:0]  bf3 [3];
    logic [31:0] ba  [3];
    logic [31:0] bwd [3];
    set_word(16, 32'h0BADF00D);
    bw[0] = 1'b0; bf3[0] = 3'b010; ba[0] = 32'h40; bwd[0] = 32'h0;
    bw[1] = 1'b1; bf3[1] = 3'b010; ba[1] = 32'h44; bwd[1] = $urandom | 32'h00008000;
    bw[2] = 1'b0; bf3[2] = 3'b000; ba[2] = 32'h45; bwd[2] = 32'h0;
    for (int i = 0; i < 3; i++) begin
      model_exec(bw[i], bf3[i], ba[i], bwd[i], e_err, e_rd, e_lat, e_nr, e_nw);
      do_req(bw[i], bf3[i], ba[i], bwd[i], 1'b1, got, err, rd, lat, nr, nw);
      n_checks++;
      if (!got || err !== e_err || rd !== e_rd || lat != e_lat || nr != e_nr || nw != e_nw) begin
        n_fail++;
        $display("FAIL b2b_%0d: got=%b err=%b rd=%h lat=%0d r=%0d w=%0d, required err=%b rd=%h lat=%0d r=%0d w=%0d",
                 i, got, err, rd, lat, nr, nw, e_err, e_rd, e_lat, e_nr, e_nw);
      end
    end
    bus.req_valid = 1'b0;
    r0 = rd_total + wr_total;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      if (bus.resp_valid) seen++;
    end
    n_checks++;
    if (seen != 0 || rd_total + wr_total != r0) begin
      n_fail++;
      $display("FAIL b2b_tail: extra resp=%0d extra strobes=%0d, required 0 0",
               seen, rd_total + wr_total - r0);
    end
  endtask

  task automatic test_final_state();
    int bad;
    logic [31:0] w;
    n_checks++;
    if (both_total != 0) begin
      n_fail++;
      $display("FAIL strobe_overlap: cycles with read and write=%0d, required 0", both_total);
    end
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      w = {ref_bytes[4*i+3], ref_bytes[4*i+2], ref_bytes[4*i+1], ref_bytes[4*i]};
      if (tb_mem[i] !== w) begin
        if (bad < 4) $display("  memory word %0d = %h, model %h", i, tb_mem[i], w);
        bad++;
      end
    end
    n_checks++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL memory_image: %0d differing words, required 0", bad);
    end
  endtask

  initial begin
    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    @(negedge clock);
    test_reset();
    test_directed();
    test_random();
    test_reset_mid_write();
    test_back_to_back();
    test_final_state();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
